// File: rtl/led_mode_ctrl.sv
// Multi-channel LED mode controller: per-channel 3-bit mode from switches, shared blink/breathe timebase.
// Build option: define LED_DEBOUNCE_EN to filter the synchronised switch bus before modes load.
module led_mode_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int TICK_DIV     = 25_000_000,
  parameter int SLOW_TICKS   = 2,
  parameter int FAST_TICKS   = 1,
  parameter int PWM_W        = 8,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*NUM_CH-1:0]   sw,
  input  logic [PWM_W-1:0]      duty,
  output logic [NUM_CH-1:0]     led
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SLOW_W = $clog2(SLOW_TICKS + 1);
  localparam int FAST_W = $clog2(FAST_TICKS + 1);
  localparam logic [PWM_W-1:0] LVL_MAX = '1;

  typedef enum logic {BR_UP, BR_DOWN} br_state_t;

  logic [3*NUM_CH-1:0] sw_s1, sw_s2, mode_reg;
  logic [PRE_W-1:0]    pre;
  logic                tick;
  logic [SLOW_W-1:0]   slow_cnt;
  logic [FAST_W-1:0]   fast_cnt;
  logic                slow_ph, fast_ph;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [PWM_W-1:0]    lvl, lvl_nxt;
  br_state_t           br_state, br_state_nxt;
  logic                pwm_on, breathe_on;
  logic [NUM_CH-1:0]   led_nxt;

  function automatic logic mode_out(input logic [2:0] mode, input logic slow,
                                    input logic fast, input logic pwm, input logic breathe);
    case (mode)
      3'd1:    return 1'b1;
      3'd2:    return slow;
      3'd3:    return fast;
      3'd4:    return ~slow;
      3'd5:    return pwm;
      3'd6:    return breathe;
      default: return 1'b0;
    endcase
  endfunction

  // Stage: two-flop synchroniser on the whole switch bus
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // Stage: mode registers
`ifdef LED_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  logic [DB_W-1:0] db_cnt;

  // sw_s1 is what sw_s2 becomes next cycle, so a mismatch restarts the count as s2 changes;
  // the load then happens after sw_s2 has held one value for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      mode_reg <= '0;
    end else if (sw_s1 != sw_s2) begin
      db_cnt   <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
      mode_reg <= sw_s2;
    end else begin
      db_cnt   <= db_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) mode_reg <= '0;
    else     mode_reg <= sw_s2;
  end
`endif

  // Stage: shared timebase, blink phases and PWM counter
  assign tick = (pre == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      slow_cnt <= '0;
      slow_ph  <= 1'b0;
      fast_cnt <= '0;
      fast_ph  <= 1'b0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pre     <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        if (slow_cnt == SLOW_W'(SLOW_TICKS - 1)) begin
          slow_cnt <= '0;
          slow_ph  <= ~slow_ph;
        end else begin
          slow_cnt <= slow_cnt + 1'b1;
        end
        if (fast_cnt == FAST_W'(FAST_TICKS - 1)) begin
          fast_cnt <= '0;
          fast_ph  <= ~fast_ph;
        end else begin
          fast_cnt <= fast_cnt + 1'b1;
        end
      end
    end
  end

  // Stage: breathe level; the turn-around step leaves each endpoint for exactly one tick
  always_ff @(posedge clk) begin
    if (rst) begin
      br_state <= BR_UP;
      lvl      <= '0;
    end else begin
      br_state <= br_state_nxt;
      lvl      <= lvl_nxt;
    end
  end

  always_comb begin
    br_state_nxt = br_state;
    lvl_nxt      = lvl;
    if (tick) begin
      case (br_state)
        BR_UP: begin
          if (lvl == LVL_MAX) begin
            br_state_nxt = BR_DOWN;
            lvl_nxt      = lvl - 1'b1;
          end else begin
            lvl_nxt      = lvl + 1'b1;
          end
        end
        BR_DOWN: begin
          if (lvl == '0) begin
            br_state_nxt = BR_UP;
            lvl_nxt      = lvl + 1'b1;
          end else begin
            lvl_nxt      = lvl - 1'b1;
          end
        end
        default: begin
          br_state_nxt = BR_UP;
          lvl_nxt      = '0;
        end
      endcase
    end
  end

  // Stage: per-channel decode and registered LED drive
  assign pwm_on     = (pwm_cnt < duty);
  assign breathe_on = (pwm_cnt < lvl);

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      led_nxt[i] = mode_out(mode_reg[3*i +: 3], slow_ph, fast_ph, pwm_on, breathe_on);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) led <= '0;
    else     led <= led_nxt;
  end

endmodule
